mem_arbiter: RTL and testbench

//  Shares one unified 16-bit memory port between the CPU instruction-fetch side
//  (read-only) and data side (read/write); sits between cpu and a single memory.
//  One transaction outstanding at a time; data side has priority, with a

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_grant.sv | 60 ++++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified I/D memory port arbiter.
// Imported by the arbiter top and its grant sub-module.
package mem_arbiter_pkg;

    localparam int WORD_SIZE_DEF    = 16;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W_DEF        = 3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_arbiter_grant.sv
// Grant decision for the arbiter: data side wins ties, except
// when the streak counter says fetch has waited long enough.
module mem_arbiter_grant
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   idle,
    input  logic   i_req,
    input  logic   d_req,
    output grant_t grant
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] streak_q;
    logic [CNT_W-1:0] streak_d;

    // Pick a winner while idle; count D wins taken over a waiting I.
    always_comb begin
        grant    = GNT_NONE;
        streak_d = streak_q;
        if (idle) begin
            unique case (1'b1)
                (i_req && d_req): begin
                    if (streak_q == LIMIT) begin
                        grant    = GNT_I;
                        streak_d = '0;
                    end else begin
                        grant    = GNT_D;
                        streak_d = streak_q + CNT_W'(1);
                    end
                end
                (i_req && !d_req): begin
                    grant    = GNT_I;
                    streak_d = '0;
                end
                (!i_req && d_req): begin
                    grant = GNT_D;
                end
                default: begin
                    grant = GNT_NONE;
                end
            endcase
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access,
// one transaction at a time, with a fetch starvation guard.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_readM,
    input  logic [WORD_SIZE-1:0] i_address,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    inout  wire  [WORD_SIZE-1:0] d_data,
    output logic                 d_ready,
    output logic                 mem_readM,
    output logic                 mem_writeM,
    output logic [WORD_SIZE-1:0] mem_address,
    inout  wire  [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_ready,
    output logic                 busy
);

    arb_state_t           state_q;
    arb_state_t           state_d;
    grant_t               grant;
    mem_op_t              op_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 idle;
    logic                 d_req;

    assign idle  = (state_q == ARB_IDLE);
    assign d_req = d_readM | d_writeM;

    mem_arbiter_grant #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_grant (
        .clk     (clk),
        .reset_n (reset_n),
        .idle    (idle),
        .i_req   (i_readM),
        .d_req   (d_req),
        .grant   (grant)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winning request so later input changes are ignored.
    // Both d strobes at once is a protocol error and is taken as a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OP_READ;
        end else begin
            unique case (grant)
                GNT_I: begin
                    addr_q <= i_address;
                    op_q   <= OP_READ;
                end
                GNT_D: begin
                    addr_q  <= d_address;
                    wdata_q <= d_data;
                    op_q    <= d_writeM ? OP_WRITE : OP_READ;
                end
                default: begin
                    addr_q <= addr_q;
                end
            endcase
        end
    end

    // Next state, memory strobes and ready pulses.
    always_comb begin
        state_d    = state_q;
        mem_readM  = 1'b0;
        mem_writeM = 1'b0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                unique case (grant)
                    GNT_I:   state_d = ARB_BUSY_I;
                    GNT_D:   state_d = ARB_BUSY_D;
                    default: state_d = ARB_IDLE;
                endcase
            end
            ARB_BUSY_I: begin
                busy      = 1'b1;
                mem_readM = 1'b1;
                if (mem_ready) begin
                    i_ready = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY_D: begin
                busy       = 1'b1;
                mem_readM  = (op_q == OP_READ);
                mem_writeM = (op_q == OP_WRITE);
                if (mem_ready) begin
                    d_ready = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign mem_address = addr_q;
    assign mem_data    = mem_writeM ? wdata_q : 'z;
    assign d_data      = (d_ready && op_q == OP_READ) ? mem_data : 'z;
    assign i_data      = i_ready ? mem_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;
    localparam int G_I   = 1;
    localparam int G_D   = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic        d_readM;
    logic        d_writeM;
    logic [15:0] d_address;
    wire  [15:0] d_data;
    logic        d_ready;
    logic        mem_readM;
    logic        mem_writeM;
    logic [15:0] mem_address;
    wire  [15:0] mem_data;
    logic        mem_ready;
    logic        busy;

    logic [15:0] tb_d_wdata;
    logic        tb_m_drive;
    logic [15:0] tb_m_rdata;

    int checks = 0;
    int errors = 0;
    int m_streak = 0;

    assign d_data   = d_writeM ? tb_d_wdata : 'z;
    assign mem_data = tb_m_drive ? tb_m_rdata : 'z;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_readM     (i_readM),
        .i_address   (i_address),
        .i_data      (i_data),
        .i_ready     (i_ready),
        .d_readM     (d_readM),
        .d_writeM    (d_writeM),
        .d_address   (d_address),
        .d_data      (d_data),
        .d_ready     (d_ready),
        .mem_readM   (mem_readM),
        .mem_writeM  (mem_writeM),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .busy        (busy)
    );

    // Arbitration rule: D wins ties until LIMIT D wins in a row over a
    // waiting fetch, then fetch is forced; a lone fetch clears the count.
    function automatic int model_pick(input bit i, input bit d);
        if (i && d) begin
            if (m_streak == LIMIT) begin
                m_streak = 0;
                return G_I;
            end
            m_streak = m_streak + 1;
            return G_D;
        end
        if (i) begin
            m_streak = 0;
            return G_I;
        end
        if (d) return G_D;
        return 0;
    endfunction

    task automatic clear_inputs();
        i_readM    = 1'b0;
        i_address  = '0;
        d_readM    = 1'b0;
        d_writeM   = 1'b0;
        d_address  = '0;
        tb_d_wdata = '0;
        mem_ready  = 1'b0;
        tb_m_drive = 1'b0;
        tb_m_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        m_streak = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, mem_readM, mem_writeM, i_ready, d_ready} !== 5'b0 ||
            mem_address !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rd=%b wr=%b ir=%b dr=%b addr=%h want all 0",
                     busy, mem_readM, mem_writeM, i_ready, d_ready, mem_address);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        d_writeM   = 1'b1;
        d_address  = 16'h0100;
        tb_d_wdata = 16'h1234;
        @(negedge clk);
        #1;
        checks++;
        if (mem_writeM !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_write: wr=%b busy=%b want 1 1", mem_writeM, busy);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, mem_readM, mem_writeM, d_ready} !== 4'b0 ||
            mem_address !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_write: busy=%b rd=%b wr=%b dr=%b addr=%h want 0",
                     busy, mem_readM, mem_writeM, d_ready, mem_address);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b0 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_ready: d_ready=%b i_ready=%b want 0 0", d_ready, i_ready);
        end
        @(negedge clk);
        clear_inputs();
        reset_n = 1'b1;
        m_streak = 0;
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (d_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_after: d_ready=%b busy=%b want 0 0", d_ready, busy);
            end
        end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        i_readM   = 1'b1;
        i_address = 16'h0040;
        @(negedge clk);
        #1;
        checks++;
        if (mem_readM !== 1'b1 || mem_writeM !== 1'b0 || busy !== 1'b1 ||
            mem_address !== 16'h0040 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_grant: rd=%b wr=%b busy=%b addr=%h ir=%b want 1 0 1 0040 0",
                     mem_readM, mem_writeM, busy, mem_address, i_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (i_ready !== 1'b0 || mem_readM !== 1'b1) begin
            errors++;
            $display("FAIL fetch_wait: ir=%b rd=%b want 0 1", i_ready, mem_readM);
        end
        @(negedge clk);
        mem_ready  = 1'b1;
        tb_m_drive = 1'b1;
        tb_m_rdata = 16'hA5A5;
        #1;
        checks++;
        if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL fetch_done: ir=%b dr=%b data=%h want 1 0 a5a5",
                     i_ready, d_ready, i_data);
        end
        @(negedge clk);
        mem_ready  = 1'b0;
        tb_m_drive = 1'b0;
        i_readM    = 1'b0;
        #1;
        checks++;
        if (i_ready !== 1'b0 || busy !== 1'b0 || mem_readM !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle: ir=%b busy=%b rd=%b want 0 0 0",
                     i_ready, busy, mem_readM);
        end
    endtask

    task automatic test_write();
        d_writeM   = 1'b1;
        d_address  = 16'h0100;
        tb_d_wdata = 16'h1234;
        @(negedge clk);
        #1;
        checks++;
        if (mem_writeM !== 1'b1 || mem_readM !== 1'b0 ||
            mem_data !== 16'h1234 || mem_address !== 16'h0100) begin
            errors++;
            $display("FAIL write_grant: wr=%b rd=%b data=%h addr=%h want 1 0 1234 0100",
                     mem_writeM, mem_readM, mem_data, mem_address);
        end
        tb_d_wdata = 16'hFFFF;
        d_address  = 16'hBEEF;
        @(negedge clk);
        #1;
        checks++;
        if (mem_writeM !== 1'b1 || mem_data !== 16'h1234 ||
            mem_address !== 16'h0100 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_hold: wr=%b data=%h addr=%h dr=%b want 1 1234 0100 0",
                     mem_writeM, mem_data, mem_address, d_ready);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_done: dr=%b ir=%b want 1 0", d_ready, i_ready);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        d_writeM  = 1'b0;
        #1;
        checks++;
        if (mem_writeM !== 1'b0 || d_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_idle: wr=%b dr=%b busy=%b want 0 0 0",
                     mem_writeM, d_ready, busy);
        end
        d_readM    = 1'b1;
        d_writeM   = 1'b1;
        d_address  = 16'h0200;
        tb_d_wdata = 16'h5555;
        @(negedge clk);
        #1;
        checks++;
        if (mem_writeM !== 1'b1 || mem_readM !== 1'b0 || mem_data !== 16'h5555) begin
            errors++;
            $display("FAIL write_both_strobes: wr=%b rd=%b data=%h want 1 0 5555",
                     mem_writeM, mem_readM, mem_data);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_both_done: dr=%b want 1", d_ready);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_starvation();
        string pat = "DDDDIDDDDI";
        int    exp_g;
        int    got;
        do_reset();
        i_readM   = 1'b1;
        i_address = 16'h2000;
        d_readM   = 1'b1;
        d_address = 16'h3000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            exp_g = model_pick(1'b1, 1'b1);
            got = (mem_address == 16'h2000) ? G_I :
                  (mem_address == 16'h3000) ? G_D : 0;
            checks++;
            if (got != exp_g || busy !== 1'b1) begin
                errors++;
                $display("FAIL starve_grant[%0d]: got=%0d busy=%b want %0d 1",
                         k, got, busy, exp_g);
            end
            checks++;
            if ((pat[k] == "I" && got != G_I) || (pat[k] == "D" && got != G_D)) begin
                errors++;
                $display("FAIL starve_order[%0d]: got=%0d want %s", k, got, pat[k]);
            end
            mem_ready  = 1'b1;
            tb_m_drive = 1'b1;
            tb_m_rdata = 16'(k * 16'h0111);
            #1;
            checks++;
            if ((exp_g == G_I && (i_ready !== 1'b1 || d_ready !== 1'b0 ||
                                  i_data !== tb_m_rdata)) ||
                (exp_g == G_D && (d_ready !== 1'b1 || i_ready !== 1'b0 ||
                                  d_data !== tb_m_rdata))) begin
                errors++;
                $display("FAIL starve_ready[%0d]: ir=%b dr=%b idata=%h ddata=%h want side %0d data %h",
                         k, i_ready, d_ready, i_data, d_data, exp_g, tb_m_rdata);
            end
            @(negedge clk);
            mem_ready  = 1'b0;
            tb_m_drive = 1'b0;
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_hold_change();
        i_readM   = 1'b1;
        i_address = 16'h0010;
        @(negedge clk);
        #1;
        checks++;
        if (mem_address !== 16'h0010 || mem_readM !== 1'b1) begin
            errors++;
            $display("FAIL hold_grant: addr=%h rd=%b want 0010 1", mem_address, mem_readM);
        end
        i_address = 16'h0020;
        d_readM   = 1'b1;
        d_address = 16'h0777;
        @(negedge clk);
        #1;
        checks++;
        if (mem_address !== 16'h0010 || mem_readM !== 1'b1) begin
            errors++;
            $display("FAIL hold_addr: addr=%h rd=%b want 0010 1", mem_address, mem_readM);
        end
        mem_ready  = 1'b1;
        tb_m_drive = 1'b1;
        tb_m_rdata = 16'h0F0F;
        #1;
        checks++;
        if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_data !== 16'h0F0F) begin
            errors++;
            $display("FAIL hold_done: ir=%b dr=%b data=%h want 1 0 0f0f",
                     i_ready, d_ready, i_data);
        end
        @(negedge clk);
        clear_inputs();
        m_streak = 0;
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++;
        if (i_ready !== 1'b0 || d_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_ready: ir=%b dr=%b busy=%b want 0 0 0",
                     i_ready, d_ready, busy);
        end
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || mem_readM !== 1'b0 || mem_writeM !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: busy=%b rd=%b wr=%b want 0 0 0",
                     busy, mem_readM, mem_writeM);
        end
    endtask

    task automatic test_random();
        bit          ip = 0;
        bit          dp = 0;
        bit          dw = 0;
        logic [15:0] ia = '0;
        logic [15:0] da = '0;
        logic [15:0] dwd = '0;
        logic [15:0] exp_addr;
        logic [15:0] rd;
        bit          exp_wr;
        int          g;
        int          lat;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if (!ip && ($urandom % 2 == 0)) begin
                ip = 1;
                ia = 16'($urandom);
            end
            if (!dp && ($urandom % 2 == 0)) begin
                dp  = 1;
                dw  = 1'($urandom % 2);
                da  = 16'($urandom);
                dwd = 16'($urandom);
            end
            if (!ip && !dp) begin
                ip = 1;
                ia = 16'($urandom);
            end
            i_readM    = ip;
            i_address  = ia;
            d_readM    = dp && !dw;
            d_writeM   = dp && dw;
            d_address  = da;
            tb_d_wdata = dwd;
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_idle[%0d]: busy=%b want 0", n, busy);
            end
            if ($urandom % 4 == 0) begin
                mem_ready = 1'b1;
                #1;
                checks++;
                if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_stray[%0d]: ir=%b dr=%b want 0 0",
                             n, i_ready, d_ready);
                end
                mem_ready = 1'b0;
            end
            g = model_pick(ip, dp);
            exp_addr = (g == G_I) ? ia : da;
            exp_wr = (g == G_D) && dw;
            @(negedge clk);
            #1;
            checks++;
            if (busy !== 1'b1 || mem_address !== exp_addr ||
                mem_writeM !== exp_wr || mem_readM !== !exp_wr ||
                (exp_wr && mem_data !== dwd)) begin
                errors++;
                $display("FAIL rand_grant[%0d]: addr=%h rd=%b wr=%b data=%h want addr %h wr %b data %h side %0d",
                         n, mem_address, mem_readM, mem_writeM, mem_data,
                         exp_addr, exp_wr, dwd, g);
            end
            i_address  = 16'($urandom);
            d_address  = 16'($urandom);
            tb_d_wdata = 16'($urandom);
            lat = int'($urandom % 4);
            repeat (lat) begin
                @(negedge clk);
                #1;
                checks++;
                if (busy !== 1'b1 || mem_address !== exp_addr ||
                    mem_writeM !== exp_wr || i_ready !== 1'b0 ||
                    d_ready !== 1'b0 || (exp_wr && mem_data !== dwd)) begin
                    errors++;
                    $display("FAIL rand_hold[%0d]: addr=%h wr=%b data=%h ir=%b dr=%b want %h %b %h",
                             n, mem_address, mem_writeM, mem_data,
                             i_ready, d_ready, exp_addr, exp_wr, dwd);
                end
            end
            rd = 16'($urandom);
            mem_ready  = 1'b1;
            tb_m_drive = !exp_wr;
            tb_m_rdata = rd;
            #1;
            checks++;
            if ((g == G_I && (i_ready !== 1'b1 || d_ready !== 1'b0 || i_data !== rd)) ||
                (g == G_D && (d_ready !== 1'b1 || i_ready !== 1'b0 ||
                              (!exp_wr && d_data !== rd)))) begin
                errors++;
                $display("FAIL rand_ready[%0d]: ir=%b dr=%b idata=%h ddata=%h want side %0d data %h",
                         n, i_ready, d_ready, i_data, d_data, g, rd);
            end
            @(negedge clk);
            mem_ready  = 1'b0;
            tb_m_drive = 1'b0;
            if (g == G_I) ip = 0;
            else dp = 0;
        end
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_starvation();
        test_hold_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
